// File: rtl/inst_encoder_pkg.sv
// Shared encoder definitions: format codes, NOP, immediate limits.
// Also hosts the pack/check helpers and the immediate generator.
package inst_encoder_pkg;

  typedef enum logic [2:0] {
    FMT_I    = 3'd0,
    FMT_S    = 3'd1,
    FMT_B    = 3'd2,
    FMT_JAL  = 3'd3,
    FMT_U    = 3'd4,
    FMT_JALR = 3'd5
  } fmt_e;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int ENC_W = 33;

  localparam int IMM12_MIN = -2048;
  localparam int IMM12_MAX = 2047;
  localparam int IMM13_MIN = -4096;
  localparam int IMM13_MAX = 4094;
  localparam int IMM21_MIN = -1048576;
  localparam int IMM21_MAX = 1048574;

  function automatic logic imm_bad(
    input logic [2:0]  sel,
    input logic [31:0] imm
  );
    logic signed [31:0] v;
    logic bad;
    v = imm;
    case (sel)
      FMT_I, FMT_S:
        bad = (v < IMM12_MIN) || (v > IMM12_MAX);
      FMT_JALR:
        bad = (v < IMM12_MIN) || (v > IMM12_MAX)
              || imm[0];
      FMT_B:
        bad = (v < IMM13_MIN) || (v > IMM13_MAX)
              || imm[0];
      FMT_JAL:
        bad = (v < IMM21_MIN) || (v > IMM21_MAX)
              || imm[0];
      FMT_U:
        bad = imm[11:0] != 12'd0;
      default:
        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] pack(
    input logic [2:0]  sel,
    input logic [31:0] imm,
    input logic [6:0]  op,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [2:0]  f3
  );
    logic [31:0] w;
    case (sel)
      FMT_I, FMT_JALR:
        w = {imm[11:0], rs1, f3, rd, op};
      FMT_S:
        w = {imm[11:5], rs2, rs1, f3,
             imm[4:0], op};
      FMT_B:
        w = {imm[12], imm[10:5], rs2, rs1, f3,
             imm[4:1], imm[11], op};
      FMT_JAL:
        w = {imm[20], imm[10:1], imm[11],
             imm[19:12], rd, op};
      FMT_U:
        w = {imm[31:12], rd, op};
      default:
        w = 32'd0;
    endcase
    return w;
  endfunction

  // Recovers the sign-extended immediate from an encoded word.
  function automatic logic [31:0] imm_gen(
    input logic [2:0]  sel,
    input logic [31:0] w
  );
    logic [31:0] imm;
    case (sel)
      FMT_I, FMT_JALR:
        imm = {{20{w[31]}}, w[31:20]};
      FMT_S:
        imm = {{20{w[31]}}, w[31:25], w[11:7]};
      FMT_B:
        imm = {{20{w[31]}}, w[7], w[30:25],
               w[11:8], 1'b0};
      FMT_JAL:
        imm = {{12{w[31]}}, w[19:12], w[20],
               w[30:21], 1'b0};
      FMT_U:
        imm = {w[31:12], 12'd0};
      default:
        imm = 32'd0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry output FIFO for encoded words.
// The head entry is presented combinationally on data.
module enc_fifo2
  import inst_encoder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [ENC_W-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic             full,
  output logic [ENC_W-1:0] data
);

  logic [ENC_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign valid   = count != 2'd0;
  assign full    = count == 2'd2;
  assign do_pop  = pop && valid;
  // A pop frees the head slot, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);
  assign data    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// RISC-V immediate/field encoder: S1 check+pack register
// feeding a two-entry output FIFO.
module inst_encoder
  import inst_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sel,
  input  logic [31:0] in_imm,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [7:0]  err_cnt
);

  logic             s1_valid;
  logic [ENC_W-1:0] s1_data;
  logic [ENC_W-1:0] entry;
  logic [ENC_W-1:0] head;
  logic             fifo_valid;
  logic             fifo_full;
  logic             pop;
  logic             s1_move;
  logic             accept;
  logic             bad;

  assign pop      = out_valid && out_ready;
  assign s1_move  = s1_valid && (!fifo_full || pop);
  assign in_ready = rst_n && (!s1_valid || s1_move);
  assign accept   = in_valid && in_ready;

  always_comb begin
    bad   = imm_bad(in_sel, in_imm);
    entry = {1'b1, NOP};
    if (!bad)
      entry = {1'b0, pack(in_sel, in_imm, in_opcode,
                          in_rd, in_rs1, in_rs2,
                          in_funct3)};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      err_cnt  <= 8'd0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_data  <= entry;
      end else if (s1_move) begin
        s1_valid <= 1'b0;
      end
      if (pop && head[ENC_W-1] && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

  enc_fifo2 u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (s1_move),
    .push_data (s1_data),
    .pop       (pop),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .data      (head)
  );

  // Outputs read as idle/zero whenever the head is empty or reset is held.
  assign out_valid = rst_n && fifo_valid;
  assign out_inst  = out_valid ? head[31:0] : 32'd0;
  assign out_err   = out_valid && head[ENC_W-1];

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: directed steps, backpressure,
// reset flush, immediate round-trip and err_cnt saturation.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_sel = 3'd0;
  logic [31:0] in_imm = 32'd0;
  logic [6:0]  in_opcode = 7'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [4:0]  in_rs1 = 5'd0;
  logic [4:0]  in_rs2 = 5'd0;
  logic [2:0]  in_funct3 = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst;
  logic        out_err;
  logic [7:0]  err_cnt;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [2:0]  sel;
    logic [31:0] imm;
    bit          rt;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_pop = 0;
  int exp_errs = 0;

  inst_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_imm    (in_imm),
    .in_opcode (in_opcode),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [32:0] obs,
                     input logic [32:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  // Reference: legality by sign-extension width, then field placement.
  function automatic logic [32:0] model(
    input logic [2:0] s, input logic [31:0] imm,
    input logic [6:0] op, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [2:0] f3);
    logic ok;
    logic [31:0] w;
    ok = 1'b0;
    w = 32'd0;
    if (s == 3'd0 || s == 3'd1 || s == 3'd5)
      ok = imm == {{20{imm[11]}}, imm[11:0]};
    if (s == 3'd5 || s == 3'd2 || s == 3'd3)
      ok = !imm[0];
    if (s == 3'd5)
      ok = ok && imm == {{20{imm[11]}}, imm[11:0]};
    if (s == 3'd2)
      ok = ok && imm == {{19{imm[12]}}, imm[12:0]};
    if (s == 3'd3)
      ok = ok && imm == {{11{imm[20]}}, imm[20:0]};
    if (s == 3'd4)
      ok = imm[11:0] == 12'd0;
    case (s)
      3'd0, 3'd5: w = {imm[11:0], rs1, f3, rd, op};
      3'd1: w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
      3'd2: w = {imm[12], imm[10:5], rs2, rs1, f3,
                 imm[4:1], imm[11], op};
      3'd3: w = {imm[20], imm[10:1], imm[11],
                 imm[19:12], rd, op};
      3'd4: w = {imm[31:12], rd, op};
      default: ok = 1'b0;
    endcase
    return ok ? {1'b0, w} : {1'b1, 32'h13};
  endfunction

  function automatic logic [31:0] decode(
    input logic [2:0] s, input logic [31:0] w);
    case (s)
      3'd0, 3'd5: return {{20{w[31]}}, w[31:20]};
      3'd1: return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd2: return {{19{w[31]}}, w[31], w[7], w[30:25],
                    w[11:8], 1'b0};
      3'd3: return {{11{w[31]}}, w[31], w[19:12], w[20],
                    w[30:21], 1'b0};
      3'd4: return {w[31:12], 12'd0};
      default: return 32'd0;
    endcase
  endfunction

  logic        stall_prev = 1'b0;
  logic [32:0] held = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && stall_prev && out_valid)
      chk("hold_stable", {out_err, out_inst}, held);
    stall_prev = rst_n && out_valid && !out_ready;
    held = {out_err, out_inst};
    if (rst_n && out_valid && out_ready) begin
      chk("word_expected", 33'(sb.size() != 0), 33'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n_pop++;
        chk("sb_inst", 33'(out_inst), 33'(e.inst));
        chk("sb_err", 33'(out_err), 33'(e.err));
        if (e.err && exp_errs < 255)
          exp_errs++;
        if (e.rt)
          chk("roundtrip", 33'(decode(e.sel, out_inst)),
              33'(e.sel == 3'd4 ? (e.imm & 32'hFFFFF000)
                                : e.imm));
      end
    end
  end

  task automatic send(
    input logic [2:0] s, input logic [31:0] imm,
    input logic [6:0] op, input logic [4:0] rd,
    input logic [4:0] rs1, input logic [4:0] rs2,
    input logic [2:0] f3, input bit rnd, input bit rt);
    logic [32:0] m;
    bit ok;
    in_sel = s; in_imm = imm; in_opcode = op;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      if (rnd)
        out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    chk("accepted", 33'(ok), 33'd1);
    if (ok) begin
      m = model(s, imm, op, rd, rs1, rs2, f3);
      sb.push_back('{m[31:0], m[32], s, imm, rt});
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 200 && sb.size() != 0; k++)
      @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drained", 33'(sb.size()), 33'd0);
  endtask

  function automatic logic [31:0] legal_imm(input logic [2:0] s);
    case (s)
      3'd0, 3'd1: return 32'($urandom_range(0, 4095)) - 32'd2048;
      3'd5: return (32'($urandom_range(0, 4095)) - 32'd2048)
                   & 32'hFFFFFFFE;
      3'd2: return (32'($urandom_range(0, 8191)) - 32'd4096)
                   & 32'hFFFFFFFE;
      3'd3: return (32'($urandom_range(0, 2097151)) - 32'd1048576)
                   & 32'hFFFFFFFE;
      default: return $urandom & 32'hFFFFF000;
    endcase
  endfunction

  initial begin
    int base;
    logic [2:0] s;
    rst_n = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 33'(in_ready), 33'd0);
    chk("rst_out_valid", 33'(out_valid), 33'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_inst", 33'(out_inst), 33'd0);
    chk("rst_out_err", 33'(out_err), 33'd0);
    chk("rst_err_cnt", 33'(err_cnt), 33'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 33'(in_ready), 33'd1);
    @(posedge clk);
    #1;

    // I-type latency and encoding
    out_ready = 1'b1;
    send(3'd0, -32'sd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 0, 1);
    chk("lat_not_yet", 33'(out_valid), 33'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 33'(out_valid), 33'd1);
    chk("i_inst", 33'(out_inst), 33'h0FFF10093);
    chk("i_err", 33'(out_err), 33'd0);

    // B-type lower bound, then misaligned
    send(3'd2, -32'sd4096, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 0, 1);
    @(posedge clk);
    #1;
    chk("b_min_inst", 33'(out_inst), 33'h080000063);
    chk("b_min_err", 33'(out_err), 33'd0);
    send(3'd2, 32'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0);
    @(posedge clk);
    #1;
    chk("b_odd_inst", 33'(out_inst), 33'h000000013);
    chk("b_odd_err", 33'(out_err), 33'd1);
    @(posedge clk);
    #1;
    chk("b_err_cnt", 33'(err_cnt), 33'd1);

    // JAL upper bound and just past it
    send(3'd3, 32'd1048574, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 0, 1);
    @(posedge clk);
    #1;
    chk("jal_max_inst", 33'(out_inst), 33'h07FFFF0EF);
    send(3'd3, 32'd1048576, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 0, 0);
    @(posedge clk);
    #1;
    chk("jal_over_err", 33'(out_err), 33'd1);
    drain();

    // Other range edges
    send(3'd0, 32'd2047, 7'h13, 5'd3, 5'd4, 5'd0, 3'd1, 0, 1);
    send(3'd0, 32'd2048, 7'h13, 5'd3, 5'd4, 5'd0, 3'd1, 0, 0);
    send(3'd1, -32'sd2048, 7'h23, 5'd0, 5'd5, 5'd6, 3'd2, 0, 1);
    send(3'd5, 32'd2, 7'h67, 5'd1, 5'd7, 5'd0, 3'd0, 0, 1);
    send(3'd5, 32'd1, 7'h67, 5'd1, 5'd7, 5'd0, 3'd0, 0, 0);
    send(3'd2, 32'd4094, 7'h63, 5'd0, 5'd1, 5'd2, 3'd1, 0, 1);
    send(3'd4, 32'h12345000, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 0, 1);
    send(3'd4, 32'h12345001, 7'h37, 5'd9, 5'd0, 5'd0, 3'd0, 0, 0);
    send(3'd6, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0);
    drain();
    chk("edge_err_cnt", 33'(err_cnt), 33'(exp_errs));

    // Backpressure: three accepted, fourth stalls
    out_ready = 1'b0;
    base = n_pop;
    send(3'd0, 32'd10, 7'h13, 5'd1, 5'd1, 5'd0, 3'd0, 0, 1);
    send(3'd1, 32'd20, 7'h23, 5'd0, 5'd2, 5'd3, 3'd2, 0, 1);
    send(3'd4, 32'hABCDE000, 7'h17, 5'd4, 5'd0, 5'd0, 3'd0, 0, 1);
    in_valid = 1'b1;
    in_sel = 3'd5;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 33'(in_ready), 33'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd5, 32'd40, 7'h67, 5'd5, 5'd6, 5'd0, 3'd0, 0, 1);
    drain();
    chk("bp_count", 33'(n_pop - base), 33'd4);

    // Reset with entries in flight
    out_ready = 1'b0;
    send(3'd7, 32'd0, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0);
    send(3'd0, 32'd5, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 0, 0);
    send(3'd2, 32'd1, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0);
    rst_n = 1'b0;
    sb.delete();
    exp_errs = 0;
    @(negedge clk);
    chk("mid_rst_in_ready", 33'(in_ready), 33'd0);
    chk("mid_rst_out_valid", 33'(out_valid), 33'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_err_cnt", 33'(err_cnt), 33'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 33'(in_ready), 33'd1);
    chk("post_rst_valid", 33'(out_valid), 33'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("no_stale", 33'(out_valid), 33'd0);

    // Random round-trip under random out_ready
    for (int i = 0; i < 60; i++) begin
      s = 3'(i % 6);
      send(s, legal_imm(s), 7'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), 3'($urandom), 1, 1);
    end
    for (int i = 0; i < 20; i++)
      send(3'($urandom), $urandom, 7'($urandom), 5'($urandom),
           5'($urandom), 5'($urandom), 3'($urandom), 1, 0);
    drain();
    chk("rand_err_cnt", 33'(err_cnt), 33'(exp_errs));

    // err_cnt saturation
    out_ready = 1'b1;
    for (int i = 0; i < 270; i++)
      send(3'd7, $urandom, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 0, 0);
    drain();
    chk("sat_err_cnt", 33'(err_cnt), 33'd255);
    chk("sat_model", 33'(err_cnt), 33'(exp_errs));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, synchronous, active-low.
REQ-003 SHALL have port in_valid, input, 1, request valid.
REQ-004 SHALL have port in_ready, output, 1, request accepted when in_valid&&in_ready.
REQ-005 SHALL have port in_sel, input, 3, immediate format: 0 I, 1 S, 2 B, 3 JAL, 4 U (LUI/AUIPC), 5 JALR.
REQ-006 SHALL have port in_imm, input, 32, signed immediate value (U: full 32-bit value).
REQ-007 SHALL have ports in_opcode (input, 7), in_rd (input, 5), in_rs1 (input, 5), in_rs2 (input, 5), in_funct3 (input, 3), as raw fields.
REQ-008 SHALL have port out_valid, output, 1, encoded word available.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts when out_valid&&out_ready.
REQ-010 SHALL have port out_inst, output, 32, encoded instruction.
REQ-011 SHALL have port out_err, output, 1, entry failed range/alignment/format check.
REQ-012 SHALL have port err_cnt, output, 8, saturating count of error entries emitted.

Function
REQ-013 SHALL pack fields: I and JALR {imm[11:0],rs1,f3,rd,op}, S {imm[11:5],rs2,rs1,f3,imm[4:0],op}, B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}, JAL {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}, U {imm[31:12],rd,op}.
REQ-014 SHALL flag an error when: I/S imm outside [-2048,2047]; JALR outside [-2048,2047] or imm[0]=1; B outside [-4096,4094] or imm[0]=1; JAL outside [-1048576,1048574] or imm[0]=1; U imm[11:0]!=0; in_sel 6 or 7.
REQ-015 SHALL emit out_inst=32'h00000013 with out_err=1 for an error entry; out_err=0 otherwise.
REQ-016 SHALL be two stages: S1 register (capture, check, pack), then 2-entry output FIFO whose head drives out_*.
REQ-017 SHALL assert in_ready when S1 is empty or S1 moves to the FIFO in the same cycle.
REQ-018 SHALL move S1 to the FIFO when FIFO has a free slot or is popped in the same cycle.
REQ-019 SHALL give 2-cycle latency from accepting edge to out_valid with the FIFO empty and out_ready=1.
REQ-020 SHALL sustain one word per cycle with out_ready held high.
REQ-021 SHALL hold out_inst/out_err stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on simultaneous push and pop with FIFO full, pop the head and push into the freed slot with no loss.
REQ-023 SHALL preserve request order; no word is dropped or duplicated under any out_ready pattern.
REQ-024 SHALL increment err_cnt on the pop of an error entry, saturating at 255.

Reset
REQ-025 SHALL, with rst_n=0 at a clk edge, clear S1 valid, FIFO pointers/count, and err_cnt; out_valid=0, in_ready=0 during reset, out_inst=0, out_err=0.
REQ-026 SHALL discard in-flight entries on reset mid-operation; in_ready=1 the first cycle after rst_n returns high.

Structure
REQ-027 SHALL place format codes (FMT_I..FMT_JALR), NOP constant, and range limits in a shared package also used by the immediate generator.
REQ-028 SHALL implement the output buffer as sub-module enc_fifo2 (2-entry, 33-bit data).

Verification
REQ-029 SHALL test: sel=0, imm=-1, rs1=2, f3=0, rd=1, op=7'h13 -> out_inst=32'hFFF10093, out_err=0, 2 cycles after accept.
REQ-030 SHALL test: sel=2, imm=-4096 then imm=3 -> first word 32'h80000063|fields, out_err=0; second out_inst=32'h00000013, out_err=1, err_cnt=1.
REQ-031 SHALL test: sel=3, imm=1048574, rd=1, op=7'h6F -> out_inst=32'h7FFFF0EF; imm=1048576 -> out_err=1.
REQ-032 SHALL test: 4 back-to-back requests with out_ready=0 -> in_ready drops after 3 accepted; release out_ready -> 4 words in order, no loss.
REQ-033 SHALL test: rst_n=0 with 3 entries in flight -> out_valid=0 next cycle, err_cnt=0, no stale word after reset.
REQ-034 SHALL test: round-trip every legal sel through the immediate generator -> regenerated immediate equals in_imm (U: in_imm with [11:0]=0).
